// File: rtl/dma_read_arbiter_pkg.sv
// Shared types for the DMA read arbiter.
//   state_e : arbiter FSM encoding (IDLE=0, ISSUE=1, RELEASE=2). The same
//             encoding is visible on the top-level dbg_state port.
package dma_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/dma_read_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i : request vector, one bit per requester
//   ptr_i : index that has highest priority this round
//   any_o : at least one request is set
//   idx_o : first set request at or after ptr_i, wrapping past N-1 to 0
module rr_pick #(
  parameter int N     = 4,
  parameter int N_WID = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [N_WID-1:0] ptr_i,
  output logic             any_o,
  output logic [N_WID-1:0] idx_o
);

  int c;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    c     = 0;
    // Scan offsets 0..N-1 from the pointer; the first hit wins.
    for (int i = 0; i < N; i++) begin
      c = int'(ptr_i) + i;
      if (c >= N) c = c - N;
      if (!any_o && req_i[c]) begin
        any_o = 1'b1;
        idx_o = N_WID'(c);
      end
    end
  end

endmodule

// File: rtl/dma_read_arbiter.sv
// Shares one DMA RAM read port between REQ_NUM requesters, one word per grant,
// round-robin order, with a watchdog that aborts a stalled DMA read.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_read      per-requester read request (level, held until its req_valid)
//   req_addr      flattened addresses, requester i at [i*RAM_WID +: RAM_WID]
//   req_valid     per-requester data valid (one-hot or zero)
//   req_word      returned word, qualified by req_valid
//   ram_dma_addr  address to DMA
//   ram_read      read strobe to DMA, held until ram_valid
//   ram_valid     DMA data valid
//   ram_word      DMA data
//   grant_idx     current / last granted requester
//   busy          FSM not in IDLE
//   timeout_err   sticky watchdog abort flag, cleared only by rst
//   dbg_state     FSM state (state_e encoding)
//
// Handshake: a requester raises req_read and holds it; the arbiter answers
// with req_valid[g] and keeps it (and req_word) until the requester drops
// req_read[g] and the DMA has dropped ram_valid. On the DMA side ram_read is
// held until ram_valid is seen; ram_read falls the cycle after. A watchdog
// abort answers the requester with req_word=0 so it never deadlocks.
module dma_read_arbiter
  import dma_read_arbiter_pkg::*;
#(
  parameter int REQ_NUM      = 4,
  parameter int REQ_NUM_WID  = 2,
  parameter int RAM_WID      = 32,
  parameter int RAM_WORD_WID = 16,
  parameter int TIMEOUT_WID  = 16,
  parameter int TIMEOUT      = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_NUM-1:0]         req_read,
  input  logic [REQ_NUM*RAM_WID-1:0] req_addr,
  output logic [REQ_NUM-1:0]         req_valid,
  output logic [RAM_WORD_WID-1:0]    req_word,
  output logic [RAM_WID-1:0]         ram_dma_addr,
  output logic                       ram_read,
  input  logic                       ram_valid,
  input  logic [RAM_WORD_WID-1:0]    ram_word,
  output logic [REQ_NUM_WID-1:0]     grant_idx,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [1:0]                 dbg_state
);

  state_e                   state_q, state_d;
  logic [REQ_NUM_WID-1:0]   rr_ptr_q, rr_ptr_d;
  logic [REQ_NUM_WID-1:0]   grant_q, grant_d;
  logic [RAM_WID-1:0]       addr_q, addr_d;
  logic                     ram_read_q, ram_read_d;
  logic [REQ_NUM-1:0]       req_valid_q, req_valid_d;
  logic [RAM_WORD_WID-1:0]  req_word_q, req_word_d;
  logic [TIMEOUT_WID-1:0]   wdog_q, wdog_d;
  logic                     timeout_err_q, timeout_err_d;

  logic                     pick_any;
  logic [REQ_NUM_WID-1:0]   pick_idx;
  logic [REQ_NUM-1:0]       grant_onehot;
  logic [REQ_NUM_WID-1:0]   next_ptr;

  rr_pick #(
    .N     (REQ_NUM),
    .N_WID (REQ_NUM_WID)
  ) u_rr_pick (
    .req_i (req_read),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_comb begin
    grant_onehot           = '0;
    grant_onehot[grant_q]  = 1'b1;
    // Priority moves to the requester after the one just served.
    next_ptr = (grant_q == REQ_NUM_WID'(REQ_NUM - 1)) ? '0 : grant_q + 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    addr_d        = addr_q;
    ram_read_d    = ram_read_q;
    req_valid_d   = req_valid_q;
    req_word_d    = req_word_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        ram_read_d = 1'b0;
        if (pick_any) begin
          grant_d    = pick_idx;
          addr_d     = req_addr[int'(pick_idx)*RAM_WID +: RAM_WID];
          ram_read_d = 1'b1;
          wdog_d     = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ram_valid) begin
          req_word_d  = ram_word;
          req_valid_d = grant_onehot;
          ram_read_d  = 1'b0;
          rr_ptr_d    = next_ptr;
          state_d     = ST_RELEASE;
        end else if (wdog_q == TIMEOUT_WID'(TIMEOUT - 1)) begin
          // Abort: answer the requester with a zero word.
          req_word_d    = '0;
          req_valid_d   = grant_onehot;
          ram_read_d    = 1'b0;
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_ptr;
          state_d       = ST_RELEASE;
        end else if (wdog_q != {TIMEOUT_WID{1'b1}}) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        // Wait for both sides to let go before the next grant.
        if (!req_read[grant_q] && !ram_valid) begin
          req_valid_d = '0;
          wdog_d      = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      addr_q        <= '0;
      ram_read_q    <= 1'b0;
      req_valid_q   <= '0;
      req_word_q    <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      addr_q        <= addr_d;
      ram_read_q    <= ram_read_d;
      req_valid_q   <= req_valid_d;
      req_word_q    <= req_word_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_valid    = req_valid_q;
  assign req_word     = req_word_q;
  assign ram_dma_addr = addr_q;
  assign ram_read     = ram_read_q;
  assign grant_idx    = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign timeout_err  = timeout_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dma_read_arbiter.sv
module tb_dma_read_arbiter;

  localparam int N  = 4;
  localparam int NW = 2;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int TO = 20;
  localparam int EW = NW + DW;
  localparam int LIMIT = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_read;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_valid;
  logic [DW-1:0]   req_word;
  logic [AW-1:0]   ram_dma_addr;
  logic            ram_read;
  logic            ram_valid;
  logic [DW-1:0]   ram_word;
  logic [NW-1:0]   grant_idx;
  logic            busy;
  logic            timeout_err;
  logic [1:0]      dbg_state;

  dma_read_arbiter #(
    .REQ_NUM(N), .REQ_NUM_WID(NW), .RAM_WID(AW), .RAM_WORD_WID(DW),
    .TIMEOUT_WID(16), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_addr(req_addr),
    .req_valid(req_valid), .req_word(req_word), .ram_dma_addr(ram_dma_addr),
    .ram_read(ram_read), .ram_valid(ram_valid), .ram_word(ram_word),
    .grant_idx(grant_idx), .busy(busy), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // ---------------- requester table (hand-chosen) ----------------
  logic [AW-1:0] addr_tab [N];
  logic [DW-1:0] word_tab [N];
  initial begin
    addr_tab[0] = 32'h0000_1000; word_tab[0] = 16'h1111;
    addr_tab[1] = 32'h0000_2008; word_tab[1] = 16'h2222;
    addr_tab[2] = 32'h0001_2344; word_tab[2] = 16'hBEEF;
    addr_tab[3] = 32'h0000_4010; word_tab[3] = 16'h4444;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_tab[i];
  end

  // ---------------- DMA model with backing store ----------------
  logic [DW-1:0] store [logic [AW-1:0]];
  int dma_lat = 2;
  bit dma_en  = 1'b1;
  int dma_cnt;
  initial for (int i = 0; i < N; i++) store[addr_tab[i]] = word_tab[i];

  always @(posedge clk) begin
    if (rst || !ram_read) begin
      dma_cnt   <= 0;
      ram_valid <= 1'b0;
      ram_word  <= '0;
    end else if (dma_en) begin
      if (dma_cnt >= dma_lat) begin
        ram_valid <= 1'b1;
        ram_word  <= store.exists(ram_dma_addr) ? store[ram_dma_addr] : 16'hDEAD;
      end else begin
        dma_cnt <= dma_cnt + 1;
      end
    end
  end

  // ---------------- requester agent ----------------
  // force_mode: 0 normal, 1 all requests high, 2 all requests low.
  int force_mode = 1;
  int remaining [N];
  initial begin
    for (int i = 0; i < N; i++) remaining[i] = 0;
    req_read = '1;
    forever begin
      @(posedge clk);
      #2;
      if (force_mode == 1) begin
        req_read = '1;
      end else if (force_mode == 2) begin
        req_read = '0;
      end else if (!rst) begin
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_read[i]) begin
            req_read[i] = 1'b0;
          end else if (!req_read[i] && !req_valid[i] && remaining[i] > 0) begin
            req_read[i]  = 1'b1;
            remaining[i] = remaining[i] - 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int tests = 0;
  int fails = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic push(input int g);
    exp_q.push_back({NW'(g), word_tab[g]});
    exp_addr_q.push_back(addr_tab[g]);
  endtask

  task automatic push_timeout(input int g);
    exp_q.push_back({NW'(g), {DW{1'b0}}});
    exp_addr_q.push_back(addr_tab[g]);
  endtask

  // ---------------- monitor ----------------
  logic          prev_rr = 1'b0;
  logic [N-1:0]  prev_rv = '0;
  logic [N-1:0]  prev_req = '0;
  int            cyc = 0;
  int            rise_cyc = 0;
  int            lat_meas = -1;
  int            rr_run = 0;
  int            last_run = 0;
  logic [EW-1:0] e;
  logic [N-1:0]  exp_oh;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if ((req_read & ~prev_req) != '0) rise_cyc = cyc;
        check("valid_onehot", 64'($onehot0(req_valid)), 64'd1);
        check("valid_in_idle", 64'(!busy && (req_valid != '0)), 64'd0);
        for (int i = 0; i < N; i++)
          if (prev_rv[i] && !req_valid[i])
            check("valid_hold", 64'(prev_req[i]), 64'd0);
        if (ram_read && !prev_rr) begin
          lat_meas = cyc - rise_cyc;
          rr_run   = 0;
          if (exp_addr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL ram_addr: unexpected ram_read with addr 0x%0h", ram_dma_addr);
          end else begin
            check("ram_addr", 64'(ram_dma_addr), 64'(exp_addr_q.pop_front()));
          end
        end
        if (ram_read) rr_run++;
        else if (prev_rr) last_run = rr_run;
        if (req_valid != '0 && prev_rv == '0) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL resp: unexpected req_valid 0x%0h", req_valid);
          end else begin
            e = exp_q.pop_front();
            exp_oh = '0;
            exp_oh[e[EW-1 -: NW]] = 1'b1;
            check("resp_valid", 64'(req_valid), 64'(exp_oh));
            check("resp_word", 64'(req_word), 64'(e[DW-1:0]));
            check("resp_grant", 64'(grant_idx), 64'(e[EW-1 -: NW]));
          end
        end
      end
      prev_rr  = ram_read;
      prev_rv  = req_valid;
      prev_req = req_read;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    force_mode = 2;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    force_mode = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    int rem;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      rem = 0;
      for (int i = 0; i < N; i++) rem += remaining[i];
    end while ((exp_q.size() != 0 || busy || req_read != '0 || rem != 0) && n < LIMIT);
    check(name, 64'(n < LIMIT), 64'd1);
  endtask

  task automatic wait_ram_read(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ram_read && n < LIMIT);
    check(name, 64'(n < LIMIT), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    // 1: reset with every request held high
    repeat (3) @(negedge clk);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_req_word", 64'(req_word), 64'd0);
    check("rst_ram_addr", 64'(ram_dma_addr), 64'd0);
    check("rst_ram_read", 64'(ram_read), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    force_mode = 2;
    @(negedge clk);
    rst = 1'b0;
    force_mode = 0;

    // 2: single request, DMA latency 12
    dma_lat = 12;
    push(2);
    remaining[2] = 1;
    wait_idle("single_done");
    check("single_latency", 64'(lat_meas), 64'd1);
    check("single_idle_valid", 64'(req_valid), 64'd0);

    // 3: fairness, all four requesting for two rounds
    do_reset();
    dma_lat = 2;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i);
    for (int i = 0; i < N; i++) remaining[i] = 2;
    wait_idle("fair_done");

    // 4: requests 1 and 3 arrive while 0 is in flight
    do_reset();
    dma_lat = 6;
    push(0); push(1); push(3);
    remaining[0] = 1;
    wait_ram_read("contend_issue");
    remaining[1] = 1;
    remaining[3] = 1;
    wait_idle("contend_done");

    // 5: watchdog abort, DMA never answers
    do_reset();
    dma_en = 1'b0;
    push_timeout(1);
    remaining[1] = 1;
    wait_idle("timeout_done");
    check("timeout_err_set", 64'(timeout_err), 64'd1);
    check("timeout_read_len", 64'(last_run), 64'(TO));
    dma_en  = 1'b1;
    dma_lat = 1;
    push(3);
    remaining[3] = 1;
    wait_idle("after_timeout_done");
    check("timeout_err_sticky", 64'(timeout_err), 64'd1);
    do_reset();
    check("timeout_err_cleared", 64'(timeout_err), 64'd0);

    // 6: reset in the middle of ISSUE
    dma_lat = 3;
    push(1);
    remaining[1] = 1;
    wait_idle("pre_abort_done");
    dma_lat = 10;
    exp_addr_q.push_back(addr_tab[2]);
    remaining[2] = 1;
    wait_ram_read("abort_issue");
    repeat (3) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    force_mode = 2;
    rst = 1'b1;
    @(negedge clk);
    check("abort_ram_read", 64'(ram_read), 64'd0);
    check("abort_req_valid", 64'(req_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    force_mode = 0;
    push(0); push(2);
    remaining[0] = 1;
    remaining[2] = 1;
    wait_idle("post_abort_done");

    repeat (3) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("exp_addr_q_empty", 64'(exp_addr_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
